// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared types and sizes for the complex-multiply arbiter slice
package cmul_pkg;

  localparam int CMUL_NUM_REQ      = 4;
  localparam int CMUL_SIZE         = 16;
  localparam int CMUL_NUM_OPERANDS = 4;
  localparam int CMUL_WIDTH        = 64;
  localparam int CMUL_MAX_INFLIGHT = 4;

  typedef logic [$clog2(CMUL_NUM_REQ)-1:0] req_id_t;
  typedef logic [CMUL_SIZE*CMUL_NUM_OPERANDS-1:0][CMUL_WIDTH-1:0] operand_vec_t;
  typedef logic [2*CMUL_SIZE-1:0][CMUL_WIDTH-1:0] result_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cmul_id_fifo.sv
// rtl/cmul_id_fifo.sv - synchronous FIFO of requester IDs, one per op in flight
module cmul_id_fifo
  import cmul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output req_id_t                  head
);

  localparam int AW = $clog2(DEPTH);

  req_id_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // DEPTH is a power of two, so the top count bit alone means full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/cmul_rr_arbiter.sv
// rtl/cmul_rr_arbiter.sv - round-robin sharing of one complex multiply datapath
// Results come back in issue order; the ID FIFO steers each one to its issuer.
module cmul_rr_arbiter
  import cmul_pkg::*;
#(
  parameter int NUM_REQ      = CMUL_NUM_REQ,
  parameter int SIZE         = CMUL_SIZE,
  parameter int NUM_OPERANDS = CMUL_NUM_OPERANDS,
  parameter int WIDTH        = CMUL_WIDTH,
  parameter int MAX_INFLIGHT = CMUL_MAX_INFLIGHT
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ*SIZE*NUM_OPERANDS*WIDTH-1:0] req_operands_i,
  output logic [NUM_REQ-1:0]                     rsp_valid_o,
  input  logic [NUM_REQ-1:0]                     rsp_ready_i,
  output logic [2*SIZE*WIDTH-1:0]                rsp_result_o,
  output logic                                   mul_in_valid_o,
  input  logic                                   mul_in_ready_i,
  output logic [SIZE*NUM_OPERANDS*WIDTH-1:0]     mul_operands_o,
  output logic                                   mul_flush_o,
  input  logic                                   mul_out_valid_i,
  output logic                                   mul_out_ready_o,
  input  logic [2*SIZE*WIDTH-1:0]                mul_result_i,
  input  logic                                   mul_busy_i,
  output logic [$clog2(MAX_INFLIGHT):0]          inflight_o,
  output logic                                   err_o
);

  arb_state_e                      state_q, state_d;
  req_id_t                         grant_q, grant_d;
  req_id_t                         rr_ptr_q, rr_ptr_d;
  req_id_t                         head;
  logic                            push, pop, clear, full, empty;
  logic                            err_q, err_set, flushing, found;
  logic [$clog2(MAX_INFLIGHT):0]   count;
  operand_vec_t [NUM_REQ-1:0]      ops_arr;
  int                              idx;

  assign ops_arr        = req_operands_i;
  assign mul_operands_o = (state_q == HOLD) ? ops_arr[grant_q] : '0;
  assign mul_flush_o    = flush_i;
  assign rsp_result_o   = mul_result_i;
  assign inflight_o     = count;
  assign err_o          = err_q;
  assign flushing       = flush_i || (state_q == FLUSH);
  assign clear          = flushing;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    push           = 1'b0;
    mul_in_valid_o = 1'b0;
    req_ready_o    = '0;
    found          = 1'b0;
    idx            = 0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && (|req_valid_i) && !full) begin
          // first requester at or after rr_ptr, wrapping
          for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req_valid_i[req_id_t'(idx)]) begin
              found   = 1'b1;
              grant_d = req_id_t'(idx);
            end
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        mul_in_valid_o = !flush_i;
        if (!flush_i && mul_in_ready_i) begin
          req_ready_o[grant_q] = 1'b1;
          push                 = 1'b1;
          rr_ptr_d             = (grant_q == req_id_t'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          state_d              = IDLE;
        end
      end
      FLUSH: begin
        if (!flush_i && !mul_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = FLUSH;
  end

  // Return steering; stale or orphan results are drained rather than stalled
  always_comb begin
    rsp_valid_o     = '0;
    mul_out_ready_o = 1'b0;
    pop             = 1'b0;
    err_set         = 1'b0;
    if (flushing) begin
      mul_out_ready_o = 1'b1;
    end else if (empty) begin
      mul_out_ready_o = 1'b1;
      err_set         = mul_out_valid_i;
    end else begin
      rsp_valid_o[head] = mul_out_valid_i;
      mul_out_ready_o   = rsp_ready_i[head];
      pop               = mul_out_valid_i && rsp_ready_i[head];
    end
  end

  cmul_id_fifo #(.DEPTH(MAX_INFLIGHT)) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .push_id (grant_q),
    .pop     (pop),
    .clear   (clear),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// tb/tb_cmul_rr_arbiter.sv - scoreboard bench for cmul_rr_arbiter with an in-order datapath model
module tb_cmul_rr_arbiter;
  import cmul_pkg::*;

  localparam int NR  = CMUL_NUM_REQ;
  localparam int W   = CMUL_WIDTH;
  localparam int SZ  = CMUL_SIZE;
  localparam int OPW = CMUL_SIZE*CMUL_NUM_OPERANDS*CMUL_WIDTH;
  localparam int RW  = 2*CMUL_SIZE*CMUL_WIDTH;
  localparam int CW  = $clog2(CMUL_MAX_INFLIGHT)+1;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i, flush_i;
  logic [NR-1:0]       req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NR*OPW-1:0]   req_operands_i;
  logic [RW-1:0]       rsp_result_o, mul_result_i;
  logic                mul_in_valid_o, mul_in_ready_i, mul_flush_o;
  logic                mul_out_valid_i, mul_out_ready_o, mul_busy_i;
  logic [OPW-1:0]      mul_operands_o;
  logic [CW-1:0]       inflight_o;
  logic                err_o;

  cmul_rr_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_operands_i(req_operands_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .mul_in_valid_o(mul_in_valid_o), .mul_in_ready_i(mul_in_ready_i),
    .mul_operands_o(mul_operands_o), .mul_flush_o(mul_flush_o),
    .mul_out_valid_i(mul_out_valid_i), .mul_out_ready_o(mul_out_ready_o),
    .mul_result_i(mul_result_i), .mul_busy_i(mul_busy_i),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  typedef struct { logic [RW-1:0] res; int due; } pipe_t;
  typedef struct { int id; logic [RW-1:0] res; } exp_t;

  pipe_t          pipe[$];
  exp_t           exp_q[$];
  int             grant_log[$];
  logic [OPW-1:0] req_ops [NR];
  int             want [NR];
  int             seq [NR];
  int             n_pass, n_total, cyc, busy_hold, stall, accepts, stalled;
  logic           inject;
  logic [RW-1:0]  last_rsp;
  logic [NR-1:0]  last_rsp_valid;
  logic [OPW-1:0] ops0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] cmul_ref(input logic [OPW-1:0] ops);
    logic [RW-1:0] r;
    real ar, ai, br, bi;
    for (int l = 0; l < SZ; l++) begin
      ar = $bitstoreal(ops[(4*l+0)*W +: W]);
      ai = $bitstoreal(ops[(4*l+1)*W +: W]);
      br = $bitstoreal(ops[(4*l+2)*W +: W]);
      bi = $bitstoreal(ops[(4*l+3)*W +: W]);
      r[(2*l)*W +: W]   = $realtobits(ar*br - ai*bi);
      r[(2*l+1)*W +: W] = $realtobits(ar*bi + ai*br);
    end
    return r;
  endfunction

  function automatic logic [OPW-1:0] const_ops(input real ar, input real ai, input real br, input real bi);
    logic [OPW-1:0] v;
    for (int l = 0; l < SZ; l++) begin
      v[(4*l+0)*W +: W] = $realtobits(ar);
      v[(4*l+1)*W +: W] = $realtobits(ai);
      v[(4*l+2)*W +: W] = $realtobits(br);
      v[(4*l+3)*W +: W] = $realtobits(bi);
    end
    return v;
  endfunction

  function automatic logic [OPW-1:0] make_ops(input int r, input int s);
    logic [OPW-1:0] v;
    for (int l = 0; l < SZ; l++) begin
      v[(4*l+0)*W +: W] = $realtobits(real'(r + 1));
      v[(4*l+1)*W +: W] = $realtobits(real'(s + 2));
      v[(4*l+2)*W +: W] = $realtobits(real'(l + 1));
      v[(4*l+3)*W +: W] = $realtobits(-real'(r + l));
    end
    return v;
  endfunction

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      req_valid_i[r] = (want[r] > 0);
      req_operands_i[r*OPW +: OPW] = req_ops[r];
    end
  endtask

  // One clock: drive requesters, sample handshakes, cross the edge, advance the datapath model.
  task automatic cycle();
    logic in_fire, out_fire, fl;
    logic [OPW-1:0] ops_sent;
    exp_t e;
    pipe_t p;
    drive();
    #1;
    in_fire  = mul_in_valid_o && mul_in_ready_i;
    out_fire = mul_out_valid_i && mul_out_ready_o;
    ops_sent = mul_operands_o;
    fl       = mul_flush_o || rst_i;
    if (mul_in_valid_o && stall > 0) stall--;
    for (int r = 0; r < NR; r++) begin
      if (req_ready_o[r]) begin
        e.id = r;
        e.res = cmul_ref(req_ops[r]);
        exp_q.push_back(e);
        grant_log.push_back(r);
        accepts++;
        if (want[r] > 0) want[r]--;
        seq[r]++;
        req_ops[r] = make_ops(r, seq[r]);
      end
      if (rsp_valid_o[r] && rsp_ready_i[r]) begin
        last_rsp = rsp_result_o;
        last_rsp_valid = rsp_valid_o;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(r), 64'hFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(r), 64'(e.id));
          check("rsp_data", 64'(rsp_result_o == e.res), 64'd1);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fl) begin
      pipe.delete();
      if (mul_flush_o) busy_hold = 4;
    end else begin
      if (out_fire && pipe.size() > 0) void'(pipe.pop_front());
      if (in_fire) begin
        p.res = cmul_ref(ops_sent);
        p.due = cyc + LAT;
        pipe.push_back(p);
      end
    end
    if (busy_hold > 0) busy_hold--;
    mul_in_ready_i  = (stall == 0);
    mul_out_valid_i = inject || (pipe.size() > 0 && pipe[0].due <= cyc);
    mul_result_i    = (pipe.size() > 0) ? pipe[0].res : '0;
    mul_busy_i      = (pipe.size() > 0) || (busy_hold > 0);
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      busy = (exp_q.size() > 0);
      for (int r = 0; r < NR; r++) if (want[r] > 0) busy = 1'b1;
      if (busy) begin
        cycle();
        n++;
      end
    end
    check(tag, 64'(!busy), 64'd1);
  endtask

  task automatic do_reset();
    for (int r = 0; r < NR; r++) want[r] = 0;
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
    exp_q.delete();
    grant_log.delete();
    accepts = 0;
  endtask

  initial begin
    int exp_order [5];
    n_pass = 0; n_total = 0; cyc = 0; busy_hold = 0; stall = 0; accepts = 0;
    inject = 1'b0; flush_i = 1'b0; rst_i = 1'b1; rsp_ready_i = 4'hF;
    mul_in_ready_i = 1'b1; mul_out_valid_i = 1'b0; mul_result_i = '0; mul_busy_i = 1'b0;
    for (int r = 0; r < NR; r++) begin
      want[r] = 0; seq[r] = 0; req_ops[r] = make_ops(r, 0);
    end
    req_valid_i = '0; req_operands_i = '0;
    @(negedge clk);

    do_reset();
    check("rst_in_valid", 64'(mul_in_valid_o), 64'd0);
    check("rst_inflight", 64'(inflight_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);

    // single requester 2: (3+2j)*(1+2j) = -1+8j on every lane
    req_ops[2] = const_ops(3.0, 2.0, 1.0, 2.0);
    want[2] = 1;
    last_rsp_valid = '0;
    run_until_done("t1_done", 40);
    check("t1_rsp_valid", 64'(last_rsp_valid), 64'h4);
    check("t1_re_lane0", last_rsp[0 +: 64], 64'hBFF0000000000000);
    check("t1_im_lane0", last_rsp[64 +: 64], 64'h4020000000000000);
    check("t1_re_lane15", last_rsp[30*64 +: 64], 64'hBFF0000000000000);
    check("t1_im_lane15", last_rsp[31*64 +: 64], 64'h4020000000000000);

    // fairness from rr_ptr=0
    do_reset();
    want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
    run_until_done("t2_done", 80);
    exp_order = '{0, 1, 2, 3, 0};
    check("t2_grant_cnt", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

    // backpressure in HOLD
    stall = 5; stalled = 0;
    want[1] = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (mul_in_valid_o && !mul_in_ready_i) begin
        if (stalled == 0) ops0 = mul_operands_o;
        check("t3_ops_req1", 64'(mul_operands_o == req_ops[1]), 64'd1);
        check("t3_ops_stable", 64'(mul_operands_o == ops0), 64'd1);
        check("t3_no_ready", 64'(req_ready_o), 64'd0);
        stalled++;
      end
    end
    check("t3_stall_cycles", 64'(stalled), 64'd5);
    run_until_done("t3_done", 40);

    // credit limit
    rsp_ready_i = 4'h0; accepts = 0;
    for (int r = 0; r < NR; r++) want[r] = 2;
    for (int i = 0; i < 30; i++) cycle();
    check("t4_accepts", 64'(accepts), 64'd4);
    check("t4_inflight", 64'(inflight_o), 64'd4);
    check("t4_in_valid", 64'(mul_in_valid_o), 64'd0);
    rsp_ready_i = 4'hF;
    run_until_done("t4_done", 120);
    check("t4_accepts_all", 64'(accepts), 64'd8);

    // flush with 3 in flight
    rsp_ready_i = 4'h0; accepts = 0;
    want[0] = 3;
    for (int i = 0; i < 40 && accepts < 3; i++) cycle();
    check("t5_accepts", 64'(accepts), 64'd3);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    exp_q.delete();
    check("t5_inflight", 64'(inflight_o), 64'd0);
    rsp_ready_i = 4'hF;
    want[3] = 1;
    run_until_done("t5_done", 60);
    check("t5_last_grant", 64'(grant_log[grant_log.size()-1]), 64'd3);
    check("t5_no_err", 64'(err_o), 64'd0);

    // reset in the middle of HOLD
    stall = 10;
    want[0] = 1;
    cycle();
    check("t6_pre_hold", 64'(mul_in_valid_o), 64'd1);
    rst_i = 1'b1;
    cycle();
    check("t6_in_valid", 64'(mul_in_valid_o), 64'd0);
    check("t6_inflight", 64'(inflight_o), 64'd0);
    check("t6_err", 64'(err_o), 64'd0);
    rst_i = 1'b0; want[0] = 0; stall = 0; exp_q.delete();
    cycle();
    cycle();

    // spurious result with an empty ID FIFO
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    check("t6_spur_ready", 64'(mul_out_ready_o), 64'd1);
    check("t6_spur_rsp", 64'(rsp_valid_o), 64'd0);
    cycle();
    check("t6_err_set", 64'(err_o), 64'd1);
    for (int i = 0; i < 3; i++) cycle();
    check("t6_err_sticky", 64'(err_o), 64'd1);
    do_reset();
    check("t6_err_clear", 64'(err_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
